// File: rtl/cpu_0_mul_pkg.sv
// Shared definitions for the multi-cycle multiply sequencer:
// op encoding, FSM states and the partial-product shift table.
package cpu_0_mul_pkg;

  localparam int MUL_DATA_W = 32;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    CORR,
    DONE
  } mul_state_e;

  // Weight of partial product idx: AL*BL, AH*BL, AL*BH, AH*BH.
  function automatic int unsigned pp_shift(
    input logic [1:0]  idx,
    input int unsigned hw
  );
    case (idx)
      2'd0:    return 0;
      2'd1:    return hw;
      2'd2:    return hw;
      default: return 2 * hw;
    endcase
  endfunction

endpackage

// File: rtl/cpu_0_mul16_reg.sv
// Pipelined HALF_W x HALF_W unsigned multiplier, MUL_LATENCY stages.
// Ports: clk, reset (async high), a_i, b_i operands, p_o product.
module cpu_0_mul16_reg #(
  parameter int HALF_W      = 16,
  parameter int MUL_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [HALF_W-1:0]     a_i,
  input  logic [HALF_W-1:0]     b_i,
  output logic [2*HALF_W-1:0]   p_o
);

  logic [2*HALF_W-1:0] p_d;
  logic [2*HALF_W-1:0] p_q [MUL_LATENCY];

  assign p_d = {{HALF_W{1'b0}}, a_i}
             * {{HALF_W{1'b0}}, b_i};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_LATENCY; i++)
        p_q[i] <= '0;
    end else begin
      p_q[0] <= p_d;
      for (int i = 1; i < MUL_LATENCY; i++)
        p_q[i] <= p_q[i-1];
    end
  end

  assign p_o = p_q[MUL_LATENCY-1];

endmodule

// File: rtl/cpu_0_mulx_seq.sv
// Multi-cycle MUL/MULXUU/MULXSU/MULXSS sequencer built on one 16x16 mult.
// Ports: clk, reset, in_* (valid/ready/src1/src2/op), flush,
//        out_* (valid/ready/result), busy.
module cpu_0_mulx_seq
  import cpu_0_mul_pkg::*;
#(
  parameter int DATA_W      = MUL_DATA_W,
  parameter int MUL_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [1:0]        in_op,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              busy
);

  localparam int HALF_W = DATA_W / 2;
  localparam int ACC_W  = 2 * DATA_W;

  mul_state_e        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] res_q, res_d;

  // Products in flight: valid bit and pp index per stage.
  logic              tagv_q [MUL_LATENCY];
  logic [1:0]        tagi_q [MUL_LATENCY];

  logic              iss_v;
  logic              flush_eff;
  logic [HALF_W-1:0] m_a, m_b;
  logic [DATA_W-1:0] m_p;
  logic              prod_v;
  logic [1:0]        prod_i;
  logic [ACC_W-1:0]  prod_ext;
  logic              s_a, s_b;
  logic [DATA_W-1:0] corr;
  logic [DATA_W-1:0] hi_c;

  assign in_ready   = (state_q == IDLE) & ~reset;
  assign busy       = (state_q != IDLE);
  assign out_valid  = vld_q;
  assign out_result = res_q;
  assign flush_eff  = flush & busy;

  assign m_a = idx_q[0] ? a_q[DATA_W-1:HALF_W]
                        : a_q[HALF_W-1:0];
  assign m_b = idx_q[1] ? b_q[DATA_W-1:HALF_W]
                        : b_q[HALF_W-1:0];

  cpu_0_mul16_reg #(
    .HALF_W      (HALF_W),
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .a_i   (m_a),
    .b_i   (m_b),
    .p_o   (m_p)
  );

  assign prod_v   = tagv_q[MUL_LATENCY-1];
  assign prod_i   = tagi_q[MUL_LATENCY-1];
  assign prod_ext = {{DATA_W{1'b0}}, m_p};

  // Unsigned product fixed up to signed: subtract the
  // other operand for each negative signed operand.
  assign s_a  = op_q[1];
  assign s_b  = (op_q == OP_MULXSS);
  assign corr = ((s_a & a_q[DATA_W-1]) ? b_q : '0)
              + ((s_b & b_q[DATA_W-1]) ? a_q : '0);
  assign hi_c = acc_q[ACC_W-1:DATA_W] - corr;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    vld_d   = vld_q;
    res_d   = res_q;
    iss_v   = 1'b0;

    if (prod_v)
      acc_d = acc_q + (prod_ext <<
              pp_shift(prod_i, HALF_W));

    unique case (state_q)
      IDLE: begin
        if (in_valid & in_ready) begin
          a_d     = in_src1;
          b_d     = in_src2;
          op_d    = in_op;
          acc_d   = '0;
          idx_d   = 2'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        iss_v = 1'b1;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (prod_v && prod_i == 2'd3)
          state_d = CORR;
      end
      CORR: begin
        res_d   = (op_q == OP_MUL)
                ? acc_q[DATA_W-1:0] : hi_c;
        vld_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_eff) begin
      state_d = IDLE;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        tagv_q[i] <= 1'b0;
        tagi_q[i] <= '0;
      end
    end else begin
      tagv_q[0] <= iss_v & ~flush_eff;
      tagi_q[0] <= idx_q;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tagv_q[i] <= tagv_q[i-1] & ~flush_eff;
        tagi_q[i] <= tagi_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_cpu_0_mulx_seq.sv
// Self-checking bench for cpu_0_mulx_seq: vector table,
// randomized ops against a 64-bit arithmetic model, corner sequences.
module tb_cpu_0_mulx_seq;
  import cpu_0_mul_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [1:0]  in_op;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  cpu_0_mulx_seq dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_op      (in_op),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: extend each operand by its signedness to 64 bits,
  // multiply mod 2^64 and pick the requested word.
  function automatic logic [31:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == OP_MULXSU || op == OP_MULXSS)
       ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (op == OP_MULXSS) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 30);
  endtask

  task automatic run_op(input string nm,
                        input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int hold);
    int lat;
    issue(op, a, b);
    wait_valid(lat);
    chk({nm, " latency"}, 32'(lat), 32'd6);
    chk({nm, " result"}, out_result, exp);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, " ovalid_clr"}, {31'b0, out_valid}, 32'd0);
    chk({nm, " in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] held;
    logic        seen;
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    logic [31:0] corner [4];

    vt[0] = '{"uu_ff",  OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vt[1] = '{"mul_m2", OP_MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE};
    vt[2] = '{"ss_m2",  OP_MULXSS, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    vt[3] = '{"uu_m2",  OP_MULXUU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    vt[4] = '{"su_min", OP_MULXSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vt[5] = '{"ss_min", OP_MULXSS, 32'h80000000, 32'h80000000, 32'h40000000};
    vt[6] = '{"uu_16",  OP_MULXUU, 32'h00010000, 32'h00010000, 32'h00000001};
    corner[0] = 32'h00000000;
    corner[1] = 32'hFFFFFFFF;
    corner[2] = 32'h80000000;
    corner[3] = 32'h7FFFFFFF;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_src1   = '0;
    in_src2   = '0;
    in_op     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst out_result", out_result, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post rst in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 7; i++)
      run_op(vt[i].nm, vt[i].op, vt[i].a, vt[i].b, vt[i].exp, 0);

    for (int i = 0; i < 30; i++) begin
      ra  = ($urandom_range(3) == 0) ? corner[$urandom_range(3)]
                                      : $urandom;
      rb  = ($urandom_range(3) == 0) ? corner[$urandom_range(3)]
                                      : $urandom;
      rop = 2'($urandom_range(3));
      run_op("rand", rop, ra, rb, model(rop, ra, rb),
             $urandom_range(3));
    end

    // Stall: result held, new requests ignored, no accept on handshake.
    issue(OP_MULXSS, 32'h7FFFFFFF, 32'h80000000);
    wait_valid(lat);
    held = out_result;
    chk("stall result", held,
        model(OP_MULXSS, 32'h7FFFFFFF, 32'h80000000));
    in_valid = 1'b1;
    in_src1  = 32'h5;
    in_src2  = 32'h7;
    in_op    = OP_MUL;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall stable", out_result, held);
      chk("stall in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall out_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("hs out_valid", {31'b0, out_valid}, 32'd0);
    chk("hs no accept", {31'b0, busy}, 32'd0);
    chk("hs in_ready", {31'b0, in_ready}, 32'd1);

    // Flush mid-issue discards everything.
    issue(OP_MULXUU, 32'h12345678, 32'h9ABCDEF0);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= out_valid;
    end
    chk("flush no valid", {31'b0, seen}, 32'd0);
    run_op("post_flush", OP_MULXUU, 32'h00010000,
           32'h00010000, 32'h00000001, 0);

    // Flush wins over out_ready in DONE.
    issue(OP_MUL, 32'h3, 32'h4);
    wait_valid(lat);
    chk("done result", out_result, 32'hC);
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("done flush valid", {31'b0, out_valid}, 32'd0);
    chk("done flush busy", {31'b0, busy}, 32'd0);

    // Flush in IDLE has no effect on an accept.
    flush = 1'b1;
    issue(OP_MULXUU, 32'hFFFFFFFF, 32'h00000010);
    flush = 1'b0;
    chk("idle flush busy", {31'b0, busy}, 32'd1);
    wait_valid(lat);
    chk("idle flush lat", 32'(lat), 32'd6);
    chk("idle flush res", out_result, 32'h0000000F);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during DRAIN.
    issue(OP_MUL, 32'h12345678, 32'h9ABCDEF0);
    repeat (4) tick();
    chk("drain busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst busy", {31'b0, busy}, 32'd0);
    chk("arst in_ready", {31'b0, in_ready}, 32'd0);
    chk("arst out_result", out_result, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("arst recover", {31'b0, in_ready}, 32'd1);
    chk("arst no valid", {31'b0, out_valid}, 32'd0);
    run_op("ss_neg", OP_MULXSS, 32'hFFFFFFFE, 32'h00000003,
           32'hFFFFFFFF, 0);
    run_op("mul_neg", OP_MUL, 32'hFFFFFFFE, 32'h00000003,
           32'hFFFFFFFA, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
